// File: rtl/avalon_mm_pkg.sv
// Shared types and defaults for the Avalon-MM burst master.
package avalon_mm_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_BURST_W = 4;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    RD_DATA = 2'd2,
    WR_BEAT = 2'd3
  } state_e;

  // Largest burst a BURSTCOUNT field of burst_w bits may carry.
  function automatic int max_burst(input int burst_w);
    return 1 << (burst_w - 1);
  endfunction

endpackage

// File: rtl/avalon_timeout_cnt.sv
// Saturating up-counter that flags LIMIT consecutive enabled cycles without a clear.
// LIMIT = 0 disables the expiry output entirely.
module avalon_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign expired = (LIMIT != 0) && en && at_last;

  // Count idle cycles, holding at the last value so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_last) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/avalon_mm_burst_master.sv
// Avalon-MM burst master: pipelined burst reads, burst writes, byte enables,
// LOCK and a no-progress timeout that aborts the burst with a sticky bus_error.
module avalon_mm_burst_master
  import avalon_mm_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                CLK,
  input  logic                RST_N,
  // core side
  input  logic                start,
  input  logic                rnw,
  input  logic                lock_in,
  input  logic [ADDR_W-1:0]   address_to_access,
  input  logic [DATA_W/8-1:0] byteenable_in,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic [DATA_W-1:0]   data_to_write,
  output logic                wdata_ack,
  output logic [DATA_W-1:0]   data_read,
  output logic                rdata_valid,
  output logic                done,
  output logic                busy,
  output logic                bus_error,
  // Avalon-MM side
  output logic [ADDR_W-1:0]   ADDRESS,
  output logic [DATA_W/8-1:0] BYTEENABLE,
  output logic [BURST_W-1:0]  BURSTCOUNT,
  output logic [DATA_W-1:0]   WRITEDATA,
  output logic                READ,
  output logic                WRITE,
  output logic                BEGINTRANSFER,
  output logic                LOCK,
  input  logic [DATA_W-1:0]   READDATA,
  input  logic                READDATAVALID,
  input  logic                WAITREQUEST
);

  localparam logic [BURST_W-1:0] MAX_LEN = BURST_W'(max_burst(BURST_W));

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W/8-1:0]   be_q, be_d;
  logic [BURST_W-1:0]    len_q, len_d;
  logic [BURST_W-1:0]    beat_q, beat_d;
  logic                  lock_q, lock_d;
  logic                  begin_q, begin_d;
  logic [DATA_W-1:0]     data_read_q, data_read_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic                  done_q, done_d;
  logic                  bus_error_q, bus_error_d;

  logic                  in_read, cmd_phase, rd_beat, progress;
  logic [BURST_W-1:0]    beat_inc;
  logic                  last_beat;
  logic                  tmo_clr, tmo_en, tmo_expired, abort;

  assign in_read   = (state_q == RD_CMD) || (state_q == RD_DATA);
  assign cmd_phase = (state_q == RD_CMD) || (state_q == WR_BEAT);
  // A pipelined slave may return data while the command is still in RD_CMD.
  assign rd_beat   = in_read && READDATAVALID;
  assign progress  = (cmd_phase && !WAITREQUEST) || rd_beat;
  assign beat_inc  = beat_q + BURST_W'(1);
  assign last_beat = (beat_inc == len_q);

  // The counter is held clear in IDLE, so every burst starts from zero.
  assign tmo_clr = (state_q == IDLE) || progress;
  assign tmo_en  = (state_q != IDLE);
  assign abort   = tmo_expired && !progress;

  avalon_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Next-state, beat counting and registered-output logic for the burst FSM.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    be_d          = be_q;
    len_d         = len_q;
    beat_d        = beat_q;
    lock_d        = lock_q;
    begin_d       = 1'b0;
    data_read_d   = data_read_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    bus_error_d   = bus_error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          bus_error_d = 1'b0;
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = address_to_access;
            be_d    = byteenable_in;
            // Oversized requests are clamped to the largest legal burst.
            len_d   = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
            lock_d  = lock_in;
            beat_d  = '0;
            begin_d = 1'b1;
            state_d = rnw ? RD_CMD : WR_BEAT;
          end
        end
      end

      RD_CMD, RD_DATA: begin
        if (rd_beat) begin
          data_read_d   = READDATA;
          rdata_valid_d = 1'b1;
          beat_d        = beat_inc;
        end
        if (rd_beat && last_beat) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (abort) begin
          done_d      = 1'b1;
          bus_error_d = 1'b1;
          state_d     = IDLE;
        end else if ((state_q == RD_CMD) && !WAITREQUEST) begin
          state_d = RD_DATA;
        end
      end

      WR_BEAT: begin
        if (!WAITREQUEST) begin
          beat_d = beat_inc;
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            begin_d = 1'b1;
          end
        end else if (abort) begin
          done_d      = 1'b1;
          bus_error_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, latched command and registered core-side outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      be_q          <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      lock_q        <= 1'b0;
      begin_q       <= 1'b0;
      data_read_q   <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      lock_q        <= lock_d;
      begin_q       <= begin_d;
      data_read_q   <= data_read_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      bus_error_q   <= bus_error_d;
    end
  end

  assign READ          = (state_q == RD_CMD);
  assign WRITE         = (state_q == WR_BEAT);
  assign BEGINTRANSFER = begin_q && cmd_phase;
  assign LOCK          = lock_q && (state_q != IDLE);
  assign ADDRESS       = addr_q;
  assign BYTEENABLE    = be_q;
  assign BURSTCOUNT    = len_q;
  assign WRITEDATA     = WRITE ? data_to_write : '0;

  assign wdata_ack     = WRITE && !WAITREQUEST;
  assign data_read     = data_read_q;
  assign rdata_valid   = rdata_valid_q;
  assign done          = done_q;
  assign busy          = (state_q != IDLE);
  assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_avalon_mm_burst_master.sv
// Directed bench for avalon_mm_burst_master (TIMEOUT = 16).
module tb_avalon_mm_burst_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          start, rnw, lock_in;
  logic [AW-1:0] address_to_access;
  logic [3:0]    byteenable_in;
  logic [BW-1:0] burst_len;
  logic [DW-1:0] data_to_write;
  logic          wdata_ack;
  logic [DW-1:0] data_read;
  logic          rdata_valid, done, busy, bus_error;
  logic [AW-1:0] ADDRESS;
  logic [3:0]    BYTEENABLE;
  logic [BW-1:0] BURSTCOUNT;
  logic [DW-1:0] WRITEDATA;
  logic          READ, WRITE, BEGINTRANSFER, LOCK;
  logic [DW-1:0] READDATA;
  logic          READDATAVALID, WAITREQUEST;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DW-1:0] wd [4];

  always #5 CLK = ~CLK;

  avalon_mm_burst_master #(
    .DATA_W (DW), .ADDR_W (AW), .BURST_W (BW), .TIMEOUT (16)
  ) dut (
    .CLK (CLK), .RST_N (RST_N),
    .start (start), .rnw (rnw), .lock_in (lock_in),
    .address_to_access (address_to_access), .byteenable_in (byteenable_in),
    .burst_len (burst_len), .data_to_write (data_to_write),
    .wdata_ack (wdata_ack), .data_read (data_read), .rdata_valid (rdata_valid),
    .done (done), .busy (busy), .bus_error (bus_error),
    .ADDRESS (ADDRESS), .BYTEENABLE (BYTEENABLE), .BURSTCOUNT (BURSTCOUNT),
    .WRITEDATA (WRITEDATA), .READ (READ), .WRITE (WRITE),
    .BEGINTRANSFER (BEGINTRANSFER), .LOCK (LOCK),
    .READDATA (READDATA), .READDATAVALID (READDATAVALID), .WAITREQUEST (WAITREQUEST)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic r, input logic [BW-1:0] len, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic lk);
    start = 1'b1; rnw = r; burst_len = len; address_to_access = a;
    byteenable_in = be; lock_in = lk;
    nxt();
    start = 1'b0;
  endtask

  task automatic wr_step(input logic wr, input int beat, input logic exp_bt);
    WAITREQUEST   = wr;
    data_to_write = wd[beat];
    #1;
    chk("wr_write", WRITE, 1);
    chk("wr_wdata", WRITEDATA, wd[beat]);
    chk("wr_begin", BEGINTRANSFER, exp_bt);
    chk("wr_ack", wdata_ack, !wr);
    chk("wr_addr", ADDRESS, 32'h0000_2000);
    chk("wr_bcount", BURSTCOUNT, 4);
    chk("wr_lock", LOCK, 1);
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] pat;
    int sent, rcvd, ndone, nread, dcyc, nval;

    wd[0] = 32'h1111_0001; wd[1] = 32'h2222_0002;
    wd[2] = 32'h3333_0003; wd[3] = 32'h4444_0004;
    RST_N = 1'b0; start = 0; rnw = 0; lock_in = 0; address_to_access = '0;
    byteenable_in = '0; burst_len = '0; data_to_write = '0;
    READDATA = '0; READDATAVALID = 0; WAITREQUEST = 0;

    // reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", READ, 0);
    chk("rst_write", WRITE, 0);
    chk("rst_addr", ADDRESS, 0);
    chk("rst_berr", bus_error, 0);
    RST_N = 1'b1;
    nxt();

    // 1-beat read, minimum latency
    issue(1, 1, 32'h0000_1000, 4'hF, 0);
    #1;
    chk("r1_read", READ, 1);
    chk("r1_begin", BEGINTRANSFER, 1);
    chk("r1_addr", ADDRESS, 32'h0000_1000);
    chk("r1_bcount", BURSTCOUNT, 1);
    chk("r1_be", BYTEENABLE, 4'hF);
    chk("r1_busy", busy, 1);
    nxt();
    READDATAVALID = 1; READDATA = 32'hDEAD_BEEF;
    #1;
    chk("r1_read_c2", READ, 0);
    chk("r1_begin_c2", BEGINTRANSFER, 0);
    chk("r1_rv_c2", rdata_valid, 0);
    nxt();
    READDATAVALID = 0;
    #1;
    chk("r1_rv_c3", rdata_valid, 1);
    chk("r1_done_c3", done, 1);
    chk("r1_data", data_read, 32'hDEAD_BEEF);
    chk("r1_busy_c3", busy, 0);
    nxt();
    chk("r1_done_c4", done, 0);
    chk("r1_rv_c4", rdata_valid, 0);

    // 4-beat write, stall of 3 cycles on beat 2
    issue(0, 4, 32'h0000_2000, 4'h3, 1);
    chk("wr_be", BYTEENABLE, 4'h3);
    wr_step(0, 0, 1);
    wr_step(1, 1, 1);
    wr_step(1, 1, 0);
    wr_step(1, 1, 0);
    wr_step(0, 1, 0);
    wr_step(0, 2, 1);
    wr_step(0, 3, 1);
    WAITREQUEST = 0;
    #1;
    chk("wr_done", done, 1);
    chk("wr_write_end", WRITE, 0);
    chk("wr_lock_end", LOCK, 0);
    chk("wr_ack_end", wdata_ack, 0);
    chk("wr_busy_end", busy, 0);
    nxt();
    chk("wr_done_once", done, 0);

    // 8-beat read with READDATAVALID gaps
    issue(1, 8, 32'h0000_3000, 4'hF, 0);
    #1;
    chk("r8_read", READ, 1);
    chk("r8_bcount", BURSTCOUNT, 8);
    nxt();
    pat = 12'b1011_0110_1101;
    sent = 0; rcvd = 0; ndone = 0;
    for (int i = 0; i < 16; i++) begin
      READDATAVALID = (i < 12) ? pat[i] : 1'b0;
      READDATA = 32'hA000_0000 + sent;
      #1;
      if (rdata_valid) begin
        chk("r8_data", data_read, 32'hA000_0000 + rcvd);
        rcvd++;
      end
      if (done) begin
        ndone++;
        chk("r8_done_on_last", rcvd, 8);
      end
      if (READDATAVALID) sent++;
      nxt();
    end
    READDATAVALID = 0;
    chk("r8_count", rcvd, 8);
    chk("r8_ndone", ndone, 1);
    chk("r8_busy", busy, 0);

    // timeout with WAITREQUEST stuck high
    WAITREQUEST = 1;
    issue(1, 2, 32'h0000_4000, 4'hF, 1);
    nread = 0; dcyc = 0;
    for (int i = 1; i <= 24 && dcyc == 0; i++) begin
      #1;
      if (READ) nread++;
      if (done) dcyc = i;
      nxt();
    end
    chk("to_read_cycles", nread, 16);
    chk("to_done_cycle", dcyc, 17);
    chk("to_berr", bus_error, 1);
    chk("to_read_low", READ, 0);
    chk("to_lock_low", LOCK, 0);
    READDATAVALID = 1; READDATA = 32'hBAD0_BAD0;
    nxt();
    READDATAVALID = 0;
    #1;
    chk("to_late_rv", rdata_valid, 0);
    chk("to_berr_sticky", bus_error, 1);
    WAITREQUEST = 0;
    issue(1, 1, 32'h0000_5000, 4'hF, 0);
    chk("to_berr_clear", bus_error, 0);
    nxt();
    READDATAVALID = 1; READDATA = 32'h5555_AAAA;
    nxt();
    READDATAVALID = 0;
    chk("to_next_done", done, 1);
    chk("to_next_data", data_read, 32'h5555_AAAA);
    nxt();

    // asynchronous reset in the middle of a write
    issue(0, 4, 32'h0000_6000, 4'hF, 1);
    data_to_write = wd[0];
    #1;
    chk("rw_ack0", wdata_ack, 1);
    nxt();
    data_to_write = wd[1];
    #1;
    chk("rw_write_pre", WRITE, 1);
    RST_N = 0;
    #1;
    chk("rw_write", WRITE, 0);
    chk("rw_busy", busy, 0);
    chk("rw_lock", LOCK, 0);
    chk("rw_begin", BEGINTRANSFER, 0);
    chk("rw_ack", wdata_ack, 0);
    chk("rw_wdata", WRITEDATA, 0);
    chk("rw_addr", ADDRESS, 0);
    chk("rw_bcount", BURSTCOUNT, 0);
    nxt();
    chk("rw_no_done", done, 0);
    nxt();
    RST_N = 1;
    nxt();
    issue(1, 1, 32'h0000_7000, 4'hF, 0);
    #1;
    chk("rw_fresh_read", READ, 1);
    nxt();
    READDATAVALID = 1; READDATA = 32'h1234_5678;
    nxt();
    READDATAVALID = 0;
    chk("rw_fresh_done", done, 1);
    chk("rw_fresh_data", data_read, 32'h1234_5678);
    nxt();

    // zero-length start
    issue(1, 0, 32'h0000_0100, 4'hF, 0);
    #1;
    chk("z_done", done, 1);
    chk("z_read", READ, 0);
    chk("z_write", WRITE, 0);
    chk("z_busy", busy, 0);
    nxt();
    chk("z_done_once", done, 0);
    chk("z_read2", READ, 0);

    // start while busy is ignored
    WAITREQUEST = 1;
    issue(1, 2, 32'h0000_8000, 4'hF, 0);
    start = 1; rnw = 0; burst_len = 3; address_to_access = 32'h0000_9000;
    #1;
    chk("b_read", READ, 1);
    nxt();
    start = 0;
    #1;
    chk("b_read_held", READ, 1);
    chk("b_write", WRITE, 0);
    chk("b_addr", ADDRESS, 32'h0000_8000);
    chk("b_bcount", BURSTCOUNT, 2);
    WAITREQUEST = 0;
    nxt();
    ndone = 0; nval = 0;
    for (int i = 0; i < 6; i++) begin
      READDATAVALID = (i < 2);
      READDATA = 32'hC000_0000 + i;
      #1;
      if (done) ndone++;
      if (rdata_valid) nval++;
      nxt();
    end
    READDATAVALID = 0;
    chk("b_ndone", ndone, 1);
    chk("b_nvalid", nval, 2);
    chk("b_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
